// File: rtl/sram_loader_pkg.sv
// Shared definitions for the SRAM loader: FSM states, header field
// positions and the default number of stream beats per weight word.
package sram_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PAYLOAD = 3'd1,
    TRAILER = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Header beat layout: [15] target, [14:8] count-1, [7] reserved, [6:0] start address
  localparam int TGT_BIT  = 15;
  localparam int CNT_MSB  = 14;
  localparam int CNT_LSB  = 8;
  localparam int ADDR_MSB = 6;

  localparam int DEF_W_DATA_WIDTH = 80;
  localparam int DEF_S_WIDTH      = 16;
  localparam int W_BEATS          = DEF_W_DATA_WIDTH / DEF_S_WIDTH;

endpackage

// File: rtl/sram_loader_packer.sv
// Beat-to-word assembler: collects BEATS stream beats LSB-first into one
// wide word. The final beat is fed straight through to the top slice so the
// complete word is available in the same cycle the last beat is accepted.
module loader_packer
  import sram_loader_pkg::*;
#(
  parameter int BEATS   = W_BEATS,
  parameter int S_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       beat_valid,
  input  logic [S_WIDTH-1:0]         beat_data,
  output logic [BEATS*S_WIDTH-1:0]   word,
  output logic                       word_done
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CW-1:0] cnt_reg;

  assign word_done = beat_valid && (cnt_reg == CW'(BEATS - 1));

  // Beat counter: restarts on clear and after each completed word
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_reg <= '0;
    end else if (beat_valid) begin
      cnt_reg <= word_done ? '0 : cnt_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BEATS - 1; gi++) begin : g_slot
      logic [S_WIDTH-1:0] slot_reg;
      // Capture beat gi of the word being assembled
      always_ff @(posedge clk) begin
        if (rst) begin
          slot_reg <= '0;
        end else if (beat_valid && (cnt_reg == CW'(gi))) begin
          slot_reg <= beat_data;
        end
      end
      assign word[gi*S_WIDTH +: S_WIDTH] = slot_reg;
    end
  endgenerate

  assign word[(BEATS-1)*S_WIDTH +: S_WIDTH] = beat_data;

endmodule

// File: rtl/sram_loader.sv
// Stream-to-SRAM loader: parses a header beat, then writes payload beats to
// the input SRAM (one beat per word) or the weight SRAM (W/S beats per word).
// Optional trailer checksum check is compiled in with SRAM_LOADER_CHECKSUM_EN.
module sram_loader
  import sram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH   = 7,
  parameter int W_DATA_WIDTH = 80,
  parameter int I_DATA_WIDTH = 16,
  parameter int S_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_WIDTH-1:0]      s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    weight_we,
  output logic [ADDR_WIDTH-1:0]   weight_addr,
  output logic [W_DATA_WIDTH-1:0] weight_din,
  output logic                    input_we,
  output logic [ADDR_WIDTH-1:0]   input_addr,
  output logic [I_DATA_WIDTH-1:0] input_din,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int BEATS = W_DATA_WIDTH / S_WIDTH;

  state_t                  state_reg, state_next;
  logic                    target_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [ADDR_WIDTH-1:0]   left_reg;
  logic                    weight_we_reg, input_we_reg;
  logic [ADDR_WIDTH-1:0]   weight_addr_reg, input_addr_reg;
  logic [W_DATA_WIDTH-1:0] weight_din_reg;
  logic [I_DATA_WIDTH-1:0] input_din_reg;

  logic                    fire, hdr_fire, pay_fire;
  logic                    pack_valid, pack_done, word_write, last_word;
  logic [W_DATA_WIDTH-1:0] pack_word;

  // Ready is gated by rst so every output reads 0 while reset is held
  assign s_ready    = !rst && (state_reg == IDLE || state_reg == PAYLOAD ||
                               state_reg == TRAILER);
  assign fire       = s_valid && s_ready;
  assign hdr_fire   = fire && (state_reg == IDLE);
  assign pay_fire   = fire && (state_reg == PAYLOAD);
  assign pack_valid = pay_fire && !target_reg;
  assign word_write = pay_fire && (target_reg || pack_done);
  assign last_word  = word_write && (left_reg == '0);

  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign weight_we   = weight_we_reg;
  assign weight_addr = weight_addr_reg;
  assign weight_din  = weight_din_reg;
  assign input_we    = input_we_reg;
  assign input_addr  = input_addr_reg;
  assign input_din   = input_din_reg;

  loader_packer #(
    .BEATS   (BEATS),
    .S_WIDTH (S_WIDTH)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_reg == IDLE),
    .beat_valid (pack_valid),
    .beat_data  (s_data),
    .word       (pack_word),
    .word_done  (pack_done)
  );

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (hdr_fire) state_next = PAYLOAD;
`ifdef SRAM_LOADER_CHECKSUM_EN
      PAYLOAD: if (last_word) state_next = TRAILER;
      TRAILER: if (fire) state_next = FLUSH;
`else
      PAYLOAD: if (last_word) state_next = FLUSH;
`endif
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, header capture, address walk and registered SRAM writes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      target_reg      <= 1'b0;
      addr_reg        <= '0;
      left_reg        <= '0;
      weight_we_reg   <= 1'b0;
      weight_addr_reg <= '0;
      weight_din_reg  <= '0;
      input_we_reg    <= 1'b0;
      input_addr_reg  <= '0;
      input_din_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      weight_we_reg <= 1'b0;
      input_we_reg  <= 1'b0;
      if (hdr_fire) begin
        target_reg <= s_data[TGT_BIT];
        left_reg   <= ADDR_WIDTH'(s_data[CNT_MSB:CNT_LSB]);
        addr_reg   <= ADDR_WIDTH'(s_data[ADDR_MSB:0]);
      end
      if (word_write) begin
        if (target_reg) begin
          input_we_reg   <= 1'b1;
          input_addr_reg <= addr_reg;
          input_din_reg  <= I_DATA_WIDTH'(s_data);
        end else begin
          weight_we_reg   <= 1'b1;
          weight_addr_reg <= addr_reg;
          weight_din_reg  <= pack_word;
        end
        addr_reg <= addr_reg + 1'b1;
        left_reg <= left_reg - 1'b1;
      end
    end
  end

`ifdef SRAM_LOADER_CHECKSUM_EN
  logic [S_WIDTH-1:0] sum_reg;
  logic               mismatch_reg;
  logic               err_reg;

  // Running payload sum, trailer compare, and sticky err raised entering DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg      <= '0;
      mismatch_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      if (hdr_fire) begin
        sum_reg      <= '0;
        mismatch_reg <= 1'b0;
        err_reg      <= 1'b0;
      end
      if (pay_fire) sum_reg <= sum_reg + s_data;
      if (fire && state_reg == TRAILER) mismatch_reg <= (s_data != sum_reg);
      if (state_reg == FLUSH && mismatch_reg) err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_loader.sv
// Scoreboard bench for sram_loader: expected SRAM writes are queued as each
// load is issued and popped by a monitor whenever a write enable fires.
module tb_sram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        weight_we;
  logic [6:0]  weight_addr;
  logic [79:0] weight_din;
  logic        input_we;
  logic [6:0]  input_addr;
  logic [15:0] input_din;
  logic        busy, done, err;

  typedef struct packed {
    logic        is_input;
    logic [6:0]  addr;
    logic [79:0] data;
  } wr_t;

  wr_t sb[$];
  int  compared   = 0;
  int  mismatched = 0;

  always #5 clk = ~clk;

  sram_loader dut (
    .clk         (clk),
    .rst         (rst),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .weight_we   (weight_we),
    .weight_addr (weight_addr),
    .weight_din  (weight_din),
    .input_we    (input_we),
    .input_addr  (input_addr),
    .input_din   (input_din),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every write enable must match the head of the scoreboard
  wr_t mon_e;
  always @(negedge clk) begin
    if (rst === 1'b0 && (weight_we === 1'b1 || input_we === 1'b1)) begin
      if (weight_we && input_we) check_eq("we_exclusive", 1, 0);
      if (sb.size() == 0) begin
        check_eq("unexpected_write", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        $display("write %s addr=%0d data=%0h", input_we ? "input " : "weight",
                 input_we ? input_addr : weight_addr,
                 input_we ? {64'b0, input_din} : weight_din);
        check_eq("we_kind", {79'b0, input_we}, {79'b0, mon_e.is_input});
        check_eq("wr_addr", {73'b0, (input_we ? input_addr : weight_addr)}, {73'b0, mon_e.addr});
        check_eq("wr_data", input_we ? {64'b0, input_din} : weight_din, mon_e.data);
      end
    end
  end

  // Present one beat from a negedge, hold until accepted, return at the next negedge
  task automatic send_beat(input logic [15:0] d, input bit bubbles);
    int guard;
    int gap;
    if (bubbles) begin
      gap = $urandom_range(0, 3);
      s_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    s_data  = d;
    s_valid = 1'b1;
    guard   = 0;
    while (!s_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) check_eq("s_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Called at the negedge right after the final accepted beat
  task automatic end_checks(input bit exp_err);
    check_eq("flush_s_ready", s_ready, 0);
    check_eq("flush_busy", busy, 1);
    check_eq("flush_done", done, 0);
    @(negedge clk);
    check_eq("done_pulse", done, 1);
    check_eq("done_busy", busy, 1);
    check_eq("done_s_ready", s_ready, 0);
    check_eq("done_err", err, exp_err);
    @(negedge clk);
    check_eq("idle_done", done, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_s_ready", s_ready, 1);
    check_eq("sb_empty", sb.size(), 0);
  endtask

  task automatic load(input bit tgt, input int cnt, input logic [6:0] addr,
                      input bit bub, input logic [15:0] base);
    logic [15:0] hdr;
    logic [15:0] sum;
    logic [79:0] w;
    logic [6:0]  a;
    int          nbeats;
    hdr    = {tgt, 7'(cnt - 1), 1'b0, addr};
    a      = addr;
    sum    = '0;
    nbeats = tgt ? cnt : cnt * 5;
    for (int i = 0; i < cnt; i++) begin
      w = '0;
      if (tgt) w[15:0] = base + 16'(i);
      else for (int k = 0; k < 5; k++) w[16*k +: 16] = base + 16'(5 * i + k);
      sb.push_back('{is_input: tgt, addr: a, data: w});
      a = a + 7'd1;
    end
    send_beat(hdr, bub);
    check_eq("err_clear_on_hdr", err, 0);
    for (int i = 0; i < nbeats; i++) begin
      send_beat(base + 16'(i), bub);
      sum = sum + base + 16'(i);
    end
`ifdef SRAM_LOADER_CHECKSUM_EN
    send_beat(sum, bub);
`endif
    end_checks(1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_we", {78'b0, weight_we, input_we}, 0);
    check_eq("rst_err", err, 0);
    rst = 1'b0;
    @(negedge clk);

    load(1'b1, 4, 7'd5, 1'b0, 16'h00A0);     // header 8305
    load(1'b0, 2, 7'd100, 1'b0, 16'h0001);   // header 0164
    load(1'b1, 3, 7'd126, 1'b0, 16'h0BB0);   // address wrap
    load(1'b0, 3, 7'd10, 1'b1, 16'h1000);    // random bubbles

    // Abort mid-word: no weight write may follow
    send_beat(16'h0014, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(16'h5550 + 16'(i), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_s_ready", s_ready, 0);
    check_eq("abort_we", {78'b0, weight_we, input_we}, 0);
    rst = 1'b0;
    @(negedge clk);
    load(1'b0, 1, 7'd20, 1'b0, 16'h2000);

    load(1'b1, 128, 7'd0, 1'b0, 16'h3000);   // maximum count

`ifdef SRAM_LOADER_CHECKSUM_EN
    for (int t = 0; t < 2; t++) begin
      sb.push_back('{is_input: 1'b1, addr: 7'h10, data: 80'h1});
      sb.push_back('{is_input: 1'b1, addr: 7'h11, data: 80'h2});
      send_beat(16'h8110, 1'b0);
      send_beat(16'h0001, 1'b0);
      send_beat(16'h0002, 1'b0);
      send_beat(t == 0 ? 16'h0003 : 16'h0004, 1'b0);
      end_checks(t == 1);
    end
    repeat (3) @(negedge clk);
    check_eq("err_sticky", err, 1);
    load(1'b1, 1, 7'd40, 1'b0, 16'h4000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sram_loader.md
Name: sram_loader

Overview:
- Writer side of the weight/input SRAM interface: turns a 16-bit valid/ready command stream into SRAM write cycles.
- Fills the 80-bit weight buffer and the 16-bit input buffer, so the accelerator (the reader) can run without preloaded memory images.
- Sits beside the accelerator. The top level muxes SRAM addr/we/din to the loader while busy=1 and to the accelerator otherwise.
- Pulses done when a load completes; the top uses done as the accelerator start.

Parameters:
- ADDR_WIDTH, 7, SRAM address width (128 words).
- W_DATA_WIDTH, 80, weight SRAM word width.
- I_DATA_WIDTH, 16, input SRAM word width.
- S_WIDTH, 16, stream beat width. W_DATA_WIDTH must be a multiple of S_WIDTH; I_DATA_WIDTH must equal S_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_data  in  S_WIDTH  stream beat
- s_valid  in  1  beat valid
- s_ready  out  1  loader can accept a beat
- weight_we  out  1  weight SRAM write enable
- weight_addr  out  ADDR_WIDTH  weight SRAM address
- weight_din  out  W_DATA_WIDTH  weight SRAM write data
- input_we  out  1  input SRAM write enable
- input_addr  out  ADDR_WIDTH  input SRAM address
- input_din  out  I_DATA_WIDTH  input SRAM write data
- busy  out  1  loader owns the SRAMs
- done  out  1  one-cycle pulse when a load completes
- err  out  1  checksum mismatch (optional feature; otherwise constant 0)

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous, active-high.
- Reset values: all outputs 0; state IDLE; partial assembly discarded. A reset mid-load aborts the load with no further writes.
- Handshake: a beat transfers on a rising edge where s_valid && s_ready. s_data is held by the source until the transfer occurs.
- Header beat format:
  - [15] target: 0 = weight, 1 = input.
  - [14:8] count-1: 1..128 SRAM words.
  - [7] reserved, ignored.
  - [6:0] start address.
- States and transitions:
  - IDLE: s_ready=1. Header accepted -> PAYLOAD; latch target, start address and count.
  - PAYLOAD: s_ready=1.
    - Input target: each accepted beat at cycle T gives input_we=1 at T+1, with input_addr = current address and input_din = the beat.
    - Weight target: beats are packed LSB-first, beat k into bits [16k+15:16k]. On the 5th beat (T), weight_we=1 at T+1 with weight_din = {b4,b3,b2,b1,b0}.
    - Address increments after each SRAM write and wraps modulo 2^ADDR_WIDTH (e.g. 127 -> 0).
    - On the beat that completes the last SRAM word -> FLUSH (or TRAILER when the optional feature is compiled in).
  - FLUSH: s_ready=0; the final write's we pulse occurs in this cycle. Next state DONE.
  - DONE: s_ready=0; done=1 for exactly one cycle; -> IDLE.
- Write enables are one-cycle pulses, and weight_we and input_we are never both 1. Address and din are registered and valid only while the matching we=1.
- busy = (state != IDLE). Timing relative to the last payload beat at T: busy falls at T+3, done is at T+2.
- Bubbles: a beat gap (s_valid=0) stalls assembly with no side effects.
- The header count is exact; beats after DONE are treated as the next header.

Optional Feature:
- Macro: SRAM_LOADER_CHECKSUM_EN.
- With the macro defined:
  - Payload beats are summed modulo 2^16.
  - After the last payload beat, state TRAILER (s_ready=1) accepts one trailer beat -> FLUSH.
  - err is registered high in DONE if trailer != sum. err stays sticky until the next header is accepted or reset.
  - SRAM writes are not suppressed on mismatch.
- Without the macro: no TRAILER state, err tied 0, no accumulator.

Decomposition:
- Shared package sram_loader_pkg holds:
  - state enum (IDLE, PAYLOAD, TRAILER, FLUSH, DONE);
  - header field positions/constants (TGT_BIT=15, CNT_MSB=14, CNT_LSB=8, ADDR_MSB=6);
  - W_BEATS = W_DATA_WIDTH/S_WIDTH.
- One sub-module: loader_packer, the beat-to-word shift/assemble register with beat counter and word-complete strobe, parameterised by beat count.

Test Plan:
- Input load: header 16'h8305 (input, count 4, addr 5), beats A0..A3 back-to-back -> input_we pulses at addrs 5,6,7,8 with A0..A3; done one cycle two cycles after A3; weight_we never 1.
- Weight load: header 16'h0164 (weight, count 2, addr 100), 10 beats 0001..000A -> weight_we at addr 100 din {0005,0004,0003,0002,0001}, addr 101 din {000A,0009,0008,0007,0006}; busy falls after done.
- Wrap: input header count 3 at addr 126 -> writes at 126, 127, 0.
- Backpressure/bubbles: s_valid toggled randomly during a weight load -> identical writes to the gap-free case; s_ready=0 only in FLUSH/DONE.
- Reset mid-load: assert rst after 3 of 5 weight beats -> no weight_we, all outputs 0; a new header then loads correctly from beat 0.
- SRAM_LOADER_CHECKSUM_EN: input count 2, beats 0x0001, 0x0002:
  - trailer 0x0003 -> err=0;
  - trailer 0x0004 -> err=1 with done and held until the next header.
